// File: rtl/fpu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fpu_cmd_driver
// Description : Queues add/sub commands and issues them one at a time over the
//               fpu start/ready handshake, returning {C, tag, err} in order.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_cmd_driver #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_op,
    input  logic [31:0]                cmd_a,
    input  logic [31:0]                cmd_b,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_err,
    output logic                       fpu_start,
    output logic                       fpu_op,
    output logic [31:0]                fpu_a,
    output logic [31:0]                fpu_b,
    input  logic                       fpu_ready,
    input  logic [31:0]                fpu_c,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 65 + TAG_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_cap_ok;
    logic                 w_cap_tmo;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;

    logic [TMO_W-1:0]     r_tmo;
    logic                 w_tmo_hit;
    logic                 w_in_wait;

    logic                 r_fpu_op;
    logic [31:0]          r_fpu_a;
    logic [31:0]          r_fpu_b;
    logic [TAG_W-1:0]     r_cur_tag;
    logic [31:0]          r_rsp_data;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic                 r_rsp_err;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty && fpu_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_in_wait = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    assign w_tmo_hit = (r_tmo >= TMO_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------------
    // Command FIFO (storage carries no reset; occupancy/pointers do)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Handshake state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only a fall then a rise of fpu_ready after start completes a command;
    // a late fall on the final timeout cycle of WAIT_LO still times out.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_ok    = 1'b0;
        w_cap_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && fpu_ready) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                    w_cap_tmo   = 1'b1;
                end else if (!fpu_ready) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (fpu_ready) begin
                    w_state_nxt = S_RESP;
                    w_cap_ok    = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                    w_cap_tmo   = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Timeout counter, operand and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_pop) begin
            r_tmo <= '0;
        end else if (w_in_wait && (r_tmo != TMO_W'(TIMEOUT))) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpu_op   <= 1'b0;
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
            r_cur_tag  <= '0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_fpu_op  <= w_head[ENTRY_W-1];
                r_fpu_a   <= w_head[TAG_W+63:TAG_W+32];
                r_fpu_b   <= w_head[TAG_W+31:TAG_W];
                r_cur_tag <= w_head[TAG_W-1:0];
            end
            if (w_cap_ok) begin
                r_rsp_data <= fpu_c;
                r_rsp_tag  <= r_cur_tag;
                r_rsp_err  <= 1'b0;
            end else if (w_cap_tmo) begin
                r_rsp_data <= '0;
                r_rsp_tag  <= r_cur_tag;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign count     = r_count;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign fpu_start = (r_state == S_ISSUE);
    assign fpu_op    = r_fpu_op;
    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpu_cmd_driver
// Description : Scoreboard bench for fpu_cmd_driver with an integer-valued
//               float fpu model and randomized command/response traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_cmd_driver;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_op = 1'b0;
    logic [31:0]       cmd_a = '0;
    logic [31:0]       cmd_b = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic              fpu_start;
    logic              fpu_op;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic              fpu_ready = 1'b1;
    logic [31:0]       fpu_c = '0;
    logic              busy;
    logic [2:0]        count;

    fpu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_ready(fpu_ready), .fpu_c(fpu_c),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]      c;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;
    rsp_t sb[$];

    // Integer <-> single-precision conversion for small integer values
    function automatic logic [31:0] int_to_f32(input int n);
        int          m;
        int          p;
        logic [31:0] mm;
        if (n == 0) return 32'h0;
        m = (n < 0) ? -n : n;
        p = 0;
        for (int i = 0; i < 31; i++) if (m[i]) p = i;
        mm = 32'(m) << (23 - p);
        return {(n < 0), 8'(127 + p), mm[22:0]};
    endfunction

    function automatic int f32_to_int(input logic [31:0] x);
        int          e;
        logic [31:0] m;
        if (x[30:0] == 31'h0) return 0;
        e = int'(x[30:23]) - 127;
        m = {8'h00, 1'b1, x[22:0]} >> (23 - e);
        return x[31] ? -int'(m) : int'(m);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // fpu model: ready falls on the start edge and rises five edges later
    logic stuck  = 1'b0;
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    int   n_starts = 0;
    logic [31:0] m_c = '0;

    always @(posedge clk) begin
        if (fpu_start) begin
            check("fpu_idle_at_start", {63'h0, m_busy}, 64'h0);
            n_starts <= n_starts + 1;
            m_busy    <= 1'b1;
            fpu_ready <= 1'b0;
            m_cnt     <= 0;
            m_c <= int_to_f32(fpu_op ? f32_to_int(fpu_a) - f32_to_int(fpu_b)
                                     : f32_to_int(fpu_a) + f32_to_int(fpu_b));
        end else if (m_busy && !stuck) begin
            if (m_cnt == 4) begin
                fpu_ready <= 1'b1;
                fpu_c     <= m_c;
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Response consumer: 0 = always ready, 1 = random, 2 = stalled
    int rr_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: every cycle a response is presented it must match the head
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got tag %h data %h, expected no response",
                         rsp_tag, rsp_data);
            end else begin
                check("rsp_data", 64'(rsp_data), 64'(sb[0].c));
                check("rsp_tag",  64'(rsp_tag),  64'(sb[0].tag));
                check("rsp_err",  64'(rsp_err),  64'(sb[0].err));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at #1 after a rising edge; returns just after the handshake edge
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_c,
                        input logic exp_err);
        int   g;
        rsp_t e;
        g = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_tag = tag;
        while (!cmd_ready && g < 500) begin
            tick(1);
            g++;
        end
        if (g >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b, expected 1 within 500 cycles", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            e.c = exp_c;
            e.tag = tag;
            e.err = exp_err;
            sb.push_back(e);
            tick(1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic send_int(input logic op, input int ia, input int ib, input logic [TAG_W-1:0] tag);
        send(op, int_to_f32(ia), int_to_f32(ib), tag, int_to_f32(op ? ia - ib : ia + ib), 1'b0);
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while ((sb.size() != 0 || busy) && g < budget) begin
            tick(1);
            g++;
        end
        n_vec++;
        if (g >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: %0d responses pending after %0d cycles, expected 0",
                     sb.size(), budget);
        end
    endtask

    task automatic wait_rsp(input int budget, output int lat, output int start_at);
        lat = 0;
        start_at = -1;
        do begin
            tick(1);
            lat++;
            if (fpu_start && start_at < 0) start_at = lat;
        end while (!rsp_valid && lat < budget);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, st, s0;

        // Reset state
        tick(3);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_fpu_start", 64'(fpu_start), 64'h0);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_count",     64'(count),     64'h0);
        check("rst_rsp_data",  64'(rsp_data),  64'h0);
        check("rst_fpu_a",     64'(fpu_a),     64'h0);
        rst = 1'b0;
        tick(2);

        // 1.0 + 2.0 with latency
        rr_mode = 0;
        tick(1);
        send(1'b0, 32'h3F800000, 32'h40000000, 4'd1, 32'h40400000, 1'b0);
        wait_rsp(50, lat, st);
        check("start_latency", 64'(st), 64'd1);
        check("rsp_latency", 64'(lat), 64'd8);
        drain(100);

        // Subtraction, including an exact-zero result
        send(1'b1, 32'h40400000, 32'h3F800000, 4'd2, 32'h40000000, 1'b0);
        send(1'b1, 32'h3F800000, 32'h3F800000, 4'd3, 32'h00000000, 1'b0);
        drain(100);

        // Five back-to-back pushes fill the FIFO
        for (int i = 0; i < 5; i++) send_int(1'($urandom_range(0, 1)), 
                                              int'($urandom_range(0, 100)),
                                              int'($urandom_range(0, 100)), 4'(i));
        check("full_count", 64'(count), 64'd4);
        check("full_cmd_ready", 64'(cmd_ready), 64'h0);
        drain(300);

        // Stalled consumer: response held, no issue, FIFO fills
        rr_mode = 2;
        tick(1);
        send_int(1'b0, 7, 5, 4'd5);
        wait_rsp(50, lat, st);
        s0 = n_starts;
        for (int i = 0; i < 4; i++) send_int(1'b1, 50 + i, 3 * i, 4'(6 + i));
        tick(16);
        check("stall_no_start", 64'(n_starts), 64'(s0));
        check("stall_count", 64'(count), 64'd4);
        check("stall_cmd_ready", 64'(cmd_ready), 64'h0);
        check("stall_rsp_valid", 64'(rsp_valid), 64'h1);
        rr_mode = 0;
        drain(300);

        // Timeout, then the next issue waits for fpu_ready
        stuck = 1'b1;
        send(1'b0, 32'h3F800000, 32'h3F800000, 4'd9, 32'h0, 1'b1);
        wait_rsp(100, lat, st);
        check("tmo_latency", 64'(lat), 64'(2 + TIMEOUT));
        tick(2);
        s0 = n_starts;
        send_int(1'b0, 2, 2, 4'd10);
        tick(15);
        check("tmo_hold_issue", 64'(n_starts), 64'(s0));
        stuck = 1'b0;
        drain(100);
        check("tmo_reissue", 64'(n_starts), 64'(s0 + 1));

        // Reset in WAIT_HI with two commands queued
        send_int(1'b0, 10, 20, 4'd11);
        send_int(1'b0, 11, 21, 4'd12);
        send_int(1'b0, 12, 22, 4'd13);
        tick(2);
        check("prerst_count", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_count",     64'(count),     64'h0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("midrst_fpu_start", 64'(fpu_start), 64'h0);
        tick(2);
        rst = 1'b0;
        tick(40);
        check("postrst_busy", 64'(busy), 64'h0);

        // Randomized traffic with a random consumer
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_int(1'($urandom_range(0, 1)), int'($urandom_range(0, 200)),
                     int'($urandom_range(0, 200)), 4'($urandom_range(0, 15)));
            tick(int'($urandom_range(0, 12)));
        end
        drain(3000);
        rr_mode = 0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
